// File: rtl/display_scan_scheduler.sv
// Six-digit multiplexed 7-segment scan scheduler with time/date/alarm view selection.
// Optional edit-field blinking is built only when DISPLAY_BLINK_EN is defined.
module display_scan_scheduler #(
   parameter int SCAN_DIV      = 1000,
   parameter int BLANK_CYC     = 50,
   parameter int ROTATE_FRAMES = 500,
   parameter int BLINK_FRAMES  = 80
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [47:0] IN_TIME_SEG,
   input  logic [47:0] IN_DATE_SEG,
   input  logic [47:0] IN_ALARM_SEG,
   input  logic        IN_MERIDIAN,
   input  logic [1:0]  REQ_MODE,
   input  logic        EDIT_EN,
   input  logic [1:0]  EDIT_FIELD,
   output logic [7:0]  OUT_SEG,
   output logic [5:0]  OUT_COM,
   output logic [1:0]  OUT_VIEW,
   output logic        OUT_FRAME_TICK
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int RW = $clog2(ROTATE_FRAMES + 1);
   localparam logic [SW-1:0] SLOT_LAST   = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] BLANK_START = SW'(BLANK_CYC);
   localparam logic [RW-1:0] ROT_LAST    = RW'(ROTATE_FRAMES - 1);

   localparam logic [1:0] V_TIME  = 2'd0;
   localparam logic [1:0] V_DATE  = 2'd1;
   localparam logic [1:0] V_ALARM = 2'd2;

   // slot_cnt/digit_idx describe the position the next clock edge will present
   logic [SW-1:0] slot_cnt;
   logic [2:0]    digit_idx;
   logic [1:0]    view_q;
   logic [1:0]    view_nxt;
   logic [1:0]    prev_req;
   logic [RW-1:0] rot_cnt;
   logic [RW-1:0] rot_nxt;
   logic          frame_end;
   logic          lit;
   logic          field_blank;
   logic [47:0]   view_bus;
   logic [7:0]    digit_code;

   assign frame_end = (digit_idx == 3'd5) && (slot_cnt == SLOT_LAST);
   assign lit       = (slot_cnt >= BLANK_START);

   // The request is evaluated on the edge leaving the tick cycle, so the new
   // view is already in effect for digit 0 of the following frame.
   always_comb begin
      view_nxt = view_q;
      rot_nxt  = rot_cnt;
      if (OUT_FRAME_TICK) begin
         case (REQ_MODE)
            2'd1: begin view_nxt = V_TIME;  rot_nxt = '0; end
            2'd2: begin view_nxt = V_DATE;  rot_nxt = '0; end
            2'd3: begin view_nxt = V_ALARM; rot_nxt = '0; end
            default: begin
               if (prev_req != 2'd0) begin
                  view_nxt = V_TIME;
                  rot_nxt  = '0;
               end else if (rot_cnt == ROT_LAST) begin
                  view_nxt = (view_q == V_TIME) ? V_DATE : V_TIME;
                  rot_nxt  = '0;
               end else begin
                  rot_nxt = rot_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      case (view_nxt)
         V_TIME:  view_bus = IN_TIME_SEG;
         V_DATE:  view_bus = IN_DATE_SEG;
         default: view_bus = IN_ALARM_SEG;
      endcase
   end

   always_comb begin
      digit_code = view_bus[{digit_idx, 3'b000} +: 8];
      if ((view_nxt == V_TIME) && (digit_idx == 3'd1))
         digit_code[7] = IN_MERIDIAN;
      if (field_blank)
         digit_code = 8'h00;
   end

`ifdef DISPLAY_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (!EDIT_EN) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (OUT_FRAME_TICK) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   assign field_blank = blink_phase && (EDIT_FIELD != 2'd3) && (digit_idx[2:1] == EDIT_FIELD);
`else
   logic unused_edit;
   assign unused_edit = ^{EDIT_EN, EDIT_FIELD, 32'(BLINK_FRAMES)};
   assign field_blank = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OUT_SEG        <= 8'h00;
         OUT_COM        <= 6'b000000;
         OUT_VIEW       <= V_TIME;
         OUT_FRAME_TICK <= 1'b0;
         slot_cnt       <= '0;
         digit_idx      <= 3'd0;
         view_q         <= V_TIME;
         prev_req       <= 2'd0;
         rot_cnt        <= '0;
      end else begin
         OUT_SEG        <= lit ? digit_code : 8'h00;
         OUT_COM        <= lit ? (6'b000001 << digit_idx) : 6'b000000;
         OUT_VIEW       <= view_nxt;
         OUT_FRAME_TICK <= frame_end;
         view_q         <= view_nxt;
         rot_cnt        <= rot_nxt;
         if (OUT_FRAME_TICK)
            prev_req <= REQ_MODE;
         if (slot_cnt == SLOT_LAST) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
         end else begin
            slot_cnt <= slot_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Bench for display_scan_scheduler: frame-position reference model plus directed
// literal expectations and randomized views/requests/resets.
module tb_display_scan_scheduler;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int RF = 2;
   localparam int BF = 1;
   localparam int FR = 6 * SD;

   logic        clk;
   logic        rst;
   logic [47:0] time_seg;
   logic [47:0] date_seg;
   logic [47:0] alarm_seg;
   logic        meridian;
   logic [1:0]  req_mode;
   logic        edit_en;
   logic [1:0]  edit_field;
   logic [7:0]  seg;
   logic [5:0]  com;
   logic [1:0]  view;
   logic        tick;

   int checks = 0;
   int errors = 0;
   int tphase = 0;

   logic [7:0] time_lit  [6] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
   logic [7:0] date_lit  [6] = '{8'h07, 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39};
   logic [7:0] alarm_lit [6] = '{8'h5E, 8'h06, 8'h71, 8'h3D, 8'h76, 8'h30};
   logic [1:0] auto_views [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};

   display_scan_scheduler #(
      .SCAN_DIV(SD), .BLANK_CYC(BC), .ROTATE_FRAMES(RF), .BLINK_FRAMES(BF)
   ) dut (
      .CLK(clk), .RESET(rst),
      .IN_TIME_SEG(time_seg), .IN_DATE_SEG(date_seg), .IN_ALARM_SEG(alarm_seg),
      .IN_MERIDIAN(meridian), .REQ_MODE(req_mode),
      .EDIT_EN(edit_en), .EDIT_FIELD(edit_field),
      .OUT_SEG(seg), .OUT_COM(com), .OUT_VIEW(view), .OUT_FRAME_TICK(tick)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h required=%02h t=%0t", name, act, exp, $time);
      end
   endtask

   // reference model: output after the n-th edge since release shows frame position n-1
   int         n;
   logic [1:0] m_view;
   logic [1:0] m_prev;
   int         m_rot;
   int         m_bcnt;
   bit         m_phase;

   always @(posedge clk or posedge rst) begin
      int p, q, d, s, f;
      logic [47:0] bus;
      logic [7:0]  e_seg;
      logic [5:0]  e_com;
      logic        e_tick;
      bit          lit;
      if (rst) begin
         #1;
         chk("reset_seg",  seg, 8'h00);
         chk("reset_com",  {2'b00, com}, 8'h00);
         chk("reset_view", {6'd0, view}, 8'h00);
         chk("reset_tick", {7'd0, tick}, 8'h00);
         n = 0; m_view = 2'd0; m_prev = 2'd0; m_rot = 0; m_bcnt = 0; m_phase = 0;
      end else begin
         p = n; n = n + 1;
         f = p / FR; q = p % FR; d = q / SD; s = q % SD;
         if (q == 0 && p != 0) begin
            if (req_mode != 2'd0) begin
               m_view = req_mode - 2'd1;
               m_rot  = 0;
            end else if (m_prev != 2'd0) begin
               m_view = 2'd0;
               m_rot  = 0;
            end else begin
               m_rot++;
               if (m_rot == RF) begin
                  m_view = (m_view == 2'd0) ? 2'd1 : 2'd0;
                  m_rot  = 0;
               end
            end
            m_prev = req_mode;
         end
         bus   = (m_view == 2'd0) ? time_seg : (m_view == 2'd1) ? date_seg : alarm_seg;
         lit   = (s >= BC);
         e_seg = bus[8*d +: 8];
         if (m_view == 2'd0 && d == 1) e_seg[7] = meridian;
`ifdef DISPLAY_BLINK_EN
         if (m_phase && edit_field != 2'd3 && d / 2 == int'(edit_field)) e_seg = 8'h00;
         if (!edit_en) begin
            m_bcnt = 0; m_phase = 0;
         end else if (q == 0 && p != 0) begin
            m_bcnt++;
            if (m_bcnt == BF) begin m_bcnt = 0; m_phase = !m_phase; end
         end
`endif
         if (!lit) e_seg = 8'h00;
         e_com  = lit ? 6'(1 << d) : 6'd0;
         e_tick = (q == FR - 1);
         #1;
         chk("seg",  seg, e_seg);
         chk("com",  {2'b00, com}, {2'b00, e_com});
         chk("view", {6'd0, view}, {6'd0, m_view});
         chk("tick", {7'd0, tick}, {7'd0, e_tick});
         // hand-computed anchors for the directed phases
         case (tphase)
            1: begin
               if (d == 1 && s == 2) begin
                  chk("t1_d1_seg", seg, 8'h06);
                  chk("t1_d1_com", {2'b00, com}, 8'h02);
               end
               if (d == 5 && s == 3) chk("t1_d5_seg", seg, 8'h6D);
               if (s == 0) chk("t1_blank_com", {2'b00, com}, 8'h00);
               if (q == FR - 1) chk("t1_tick", {7'd0, tick}, 8'h01);
               if (q == FR - 2) chk("t1_notick", {7'd0, tick}, 8'h00);
            end
            2: begin
               if (d == 1 && s == 1) chk("mer_dp", seg, 8'h86);
               if (d == 0 && s == 1) chk("mer_d0", seg, 8'h3F);
            end
            3: begin
               if (d == 0 && s == 0 && f < 5) chk("auto_view", {6'd0, view}, {6'd0, auto_views[f]});
               if (d == 3 && s == 1 && (f == 2 || f == 3)) chk("auto_date", seg, 8'h77);
            end
            4: begin
               if (f == 1 && d == 3 && s == 1) begin
                  chk("pre_alarm_seg", seg, 8'h4F);
                  chk("pre_alarm_view", {6'd0, view}, 8'h00);
               end
               if (f == 2 && d == 1 && s == 1) begin
                  chk("alarm_seg", seg, 8'h06);
                  chk("alarm_view", {6'd0, view}, 8'h02);
               end
            end
            6: begin
               if (p == 1) begin
                  chk("restart_com", {2'b00, com}, 8'h01);
                  chk("restart_view", {6'd0, view}, 8'h00);
               end
            end
            7: begin
               if (d == 2 && s == 1) begin
                  chk("blink_seg", seg, (f % 2 == 1) ? 8'h00 : 8'h5B);
                  chk("blink_com", {2'b00, com}, 8'h04);
               end
            end
            default: ;
         endcase
      end
   end

   // driver tasks
   task automatic load_lits();
      for (int i = 0; i < 6; i++) begin
         time_seg[8*i +: 8]  = time_lit[i];
         date_seg[8*i +: 8]  = date_lit[i];
         alarm_seg[8*i +: 8] = alarm_lit[i];
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; meridian = 1'b0; req_mode = 2'd1; edit_en = 1'b0; edit_field = 2'd3;
      load_lits();
      repeat (3) @(negedge clk);
      tphase = 1;
      rst = 1'b0;
      repeat (48) @(negedge clk);

      tphase = 2; meridian = 1'b1;
      repeat (48) @(negedge clk);

      tphase = 3; meridian = 1'b0; req_mode = 2'd0;
      do_reset();
      repeat (125) @(negedge clk);

      tphase = 4; meridian = 1'b1; req_mode = 2'd1;
      do_reset();
      repeat (35) @(negedge clk);
      req_mode = 2'd3;
      repeat (45) @(negedge clk);

      tphase = 5;
      for (int c = 0; c < 900; c++) begin
         time_seg  = {$urandom(), 16'($urandom())};
         date_seg  = {$urandom(), 16'($urandom())};
         alarm_seg = {$urandom(), 16'($urandom())};
         meridian  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) req_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) edit_en = ~edit_en;
         if ($urandom_range(0, 49) == 0) edit_field = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) begin
            #3 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            @(negedge clk);
         end
      end

      tphase = 6; load_lits(); edit_en = 1'b0; req_mode = 2'd1;
      do_reset();
      req_mode = 2'd2;
      repeat (38) @(negedge clk);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

`ifdef DISPLAY_BLINK_EN
      tphase = 7; meridian = 1'b0; req_mode = 2'd1; edit_en = 1'b1; edit_field = 2'd1;
      do_reset();
      repeat (96) @(negedge clk);
      tphase = 5; edit_field = 2'd3;
      repeat (48) @(negedge clk);
`endif

      tphase = 0;
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
